buf_sched: RTL and testbench
============================

BUF_SCHED -- requirements
Module: buf_sched

Interface
REQ-001 SHALL have parameter TAG_W, default 8, width of request tag; buffer count fixed at 4 (2-bit index).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_vld/req1_vld  input  1  requester 0/1 lookup request valid.
REQ-005 SHALL have ports req0_tag/req1_tag  input  TAG_W  requester 0/1 block tag.
REQ-006 SHALL have ports req0_rdy/req1_rdy  output  1  request accepted this cycle (transfer on vld&rdy).
REQ-007 SHALL have port rsp_vld  output  1  response valid; rsp_id  output  1  granted requester; rsp_buf  output  2  buffer index; rsp_hit  output  1  tag was resident.
REQ-008 SHALL have port rsp_rdy  input  1  response consumer ready.
REQ-009 SHALL have port new_buf_req  output  1  one-cycle victim request to LFU unit.
REQ-010 SHALL have port ref_buf_numbr  output  2  last referenced buffer index, to LFU unit.
REQ-011 SHALL have port buf_num_replc  input  2  LFU victim index.

Function
REQ-012 SHALL hold 4 entries {valid, tag}; FSM states IDLE, LOOKUP, REQ, WAIT, RESP.
REQ-013 IDLE: SHALL grant one valid requester per cycle, round-robin; priority pointer moves to the non-granted requester after each grant; rdy asserted combinationally only to granted requester, only in IDLE.
REQ-014 Both vld same cycle SHALL resolve by pointer; pointer resets to requester 0.
REQ-015 On accept SHALL latch tag and id, go LOOKUP (1 cycle).
REQ-016 LOOKUP hit (valid & tag equal) SHALL set rsp_buf=hit index, rsp_hit=1, go RESP.
REQ-017 LOOKUP miss SHALL go REQ (see REQ-025 for prefill).
REQ-018 REQ: new_buf_req=1 for exactly one cycle, then WAIT; WAIT: sample buf_num_replc at closing edge, write tag and valid=1 into that entry, rsp_buf=sampled index, rsp_hit=0, go RESP.
REQ-019 RESP: rsp_vld=1, rsp_id/rsp_buf/rsp_hit stable until rsp_vld&rsp_rdy, then IDLE; ref_buf_numbr updated to rsp_buf on entry to RESP and held otherwise.
REQ-020 Latency (accept edge = cycle N): hit rsp_vld at N+2; LFU miss new_buf_req at N+2, rsp_vld at N+4.
REQ-021 Requests arriving outside IDLE SHALL see rdy=0 and be held by requester; no drop, no duplicate.
REQ-022 Tag table SHALL never hold duplicate valid tags.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, clear all valid bits, pointer=0, and outputs rsp_vld=0, rsp_id=0, rsp_buf=0, rsp_hit=0, new_buf_req=0, ref_buf_numbr=0, req*_rdy=0, aborting any in-flight transaction without response.
REQ-024 First grant SHALL occur on the first edge with rst_n high.

Configuration
REQ-025 Macro BUF_SCHED_PREFILL_EN defined: LOOKUP miss with any invalid entry SHALL fill lowest invalid index, rsp_hit=0, go RESP directly (rsp_vld N+2, no new_buf_req); LFU used only when all 4 valid.
REQ-026 Macro undefined: every miss SHALL go REQ/WAIT and use buf_num_replc; valid bits still qualify hits.

Verification
REQ-027 Reset then req0 tag 0x10 -> new_buf_req one pulse; buf_num_replc=2 -> rsp_buf=2, rsp_hit=0, rsp_id=0, ref_buf_numbr=2 (macro off).
REQ-028 Repeat req0 tag 0x10 -> rsp_hit=1, rsp_buf=2, rsp_vld two cycles after accept, no new_buf_req.
REQ-029 req0 and req1 valid together, pointer 0 -> req0 granted first, then req1; next simultaneous pair -> req1 first (pointer only moves to non-granted).
REQ-030 Macro on: tags 0x1,0x2,0x3,0x4 -> buffers 0,1,2,3 without new_buf_req; tag 0x5 -> new_buf_req pulse, victim from buf_num_replc.
REQ-031 rsp_rdy low 5 cycles in RESP -> rsp fields stable, req*_rdy=0; rst_n low during WAIT -> all outputs 0 at once, subsequent lookup of the in-flight tag misses.

Source files
------------

// File: rtl/buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : buf_sched
// Desc     : Two-requester buffer lookup scheduler. Arbitrates requests
//            round-robin, looks the tag up in a 4-entry {valid, tag} table
//            and, on a miss, asks an external LFU unit for a victim index
//            before filling that entry and responding.
// Options  : BUF_SCHED_PREFILL_EN - when defined, a miss fills the lowest
//            invalid entry directly; the LFU unit is only consulted once
//            all four entries are valid.
// Revision : 1.0 - initial release
// ============================================================================
module buf_sched #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_vld,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_rdy,
    input  logic             req1_vld,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_rdy,
    output logic             rsp_vld,
    output logic             rsp_id,
    output logic [1:0]       rsp_buf,
    output logic             rsp_hit,
    input  logic             rsp_rdy,
    output logic             new_buf_req,
    output logic [1:0]       ref_buf_numbr,
    input  logic [1:0]       buf_num_replc
);

    localparam int c_NUM_BUF = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    state_e             state_q;
    logic               ptr_q;
    logic [TAG_W-1:0]   tag_lat_q;
    logic               id_q;
    logic [c_NUM_BUF-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [c_NUM_BUF];

    logic               rsp_vld_q;
    logic               rsp_id_q;
    logic [1:0]         rsp_buf_q;
    logic               rsp_hit_q;
    logic               new_buf_req_q;
    logic [1:0]         ref_buf_q;

    logic               w_gnt_vld;
    logic               w_gnt_id;
    logic               w_both;
    logic [c_NUM_BUF-1:0] w_match;
    logic               w_hit;
    logic [1:0]         w_hit_idx;

    // Per-entry tag comparison against the latched request tag
    for (genvar gi = 0; gi < c_NUM_BUF; gi++) begin : g_cmp
        assign w_match[gi] = valid_q[gi] && (tag_q[gi] == tag_lat_q);
    end

    // Arbitration: pointer only breaks ties; a lone requester always wins
    always_comb begin
        w_both    = req0_vld & req1_vld;
        w_gnt_vld = req0_vld | req1_vld;
        w_gnt_id  = w_both ? ptr_q : req1_vld;
        // rdy is gated by rst_n so nothing is accepted while reset is held
        req0_rdy  = rst_n && (state_q == S_IDLE) && w_gnt_vld && !w_gnt_id;
        req1_rdy  = rst_n && (state_q == S_IDLE) && w_gnt_vld &&  w_gnt_id;
    end

    // Hit index: lowest matching entry (the table never holds duplicates)
    always_comb begin
        w_hit     = |w_match;
        w_hit_idx = 2'd0;
        for (int i = c_NUM_BUF - 1; i >= 0; i--) begin
            if (w_match[i]) w_hit_idx = 2'(i);
        end
    end

`ifdef BUF_SCHED_PREFILL_EN
    logic       w_has_free;
    logic [1:0] w_free_idx;

    // Lowest invalid entry, used to fill the table before LFU is needed
    always_comb begin
        w_has_free = ~&valid_q;
        w_free_idx = 2'd0;
        for (int i = c_NUM_BUF - 1; i >= 0; i--) begin
            if (!valid_q[i]) w_free_idx = 2'(i);
        end
    end
`endif

    // Main FSM with registered outputs and the tag table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 1'b0;
            tag_lat_q     <= '0;
            id_q          <= 1'b0;
            valid_q       <= '0;
            for (int i = 0; i < c_NUM_BUF; i++) tag_q[i] <= '0;
            rsp_vld_q     <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_buf_q     <= 2'd0;
            rsp_hit_q     <= 1'b0;
            new_buf_req_q <= 1'b0;
            ref_buf_q     <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        tag_lat_q <= w_gnt_id ? req1_tag : req0_tag;
                        id_q      <= w_gnt_id;
                        // Pointer only moves to a requester that was left waiting
                        if (w_both) ptr_q <= ~w_gnt_id;
                        state_q   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        rsp_buf_q <= w_hit_idx;
                        ref_buf_q <= w_hit_idx;
                        rsp_hit_q <= 1'b1;
                        rsp_id_q  <= id_q;
                        rsp_vld_q <= 1'b1;
                        state_q   <= S_RESP;
                    end
`ifdef BUF_SCHED_PREFILL_EN
                    else if (w_has_free) begin
                        valid_q[w_free_idx] <= 1'b1;
                        tag_q[w_free_idx]   <= tag_lat_q;
                        rsp_buf_q <= w_free_idx;
                        ref_buf_q <= w_free_idx;
                        rsp_hit_q <= 1'b0;
                        rsp_id_q  <= id_q;
                        rsp_vld_q <= 1'b1;
                        state_q   <= S_RESP;
                    end
`endif
                    else begin
                        new_buf_req_q <= 1'b1;
                        state_q       <= S_REQ;
                    end
                end
                S_REQ: begin
                    new_buf_req_q <= 1'b0;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    // Victim index from the LFU unit is taken at this edge
                    valid_q[buf_num_replc] <= 1'b1;
                    tag_q[buf_num_replc]   <= tag_lat_q;
                    rsp_buf_q <= buf_num_replc;
                    ref_buf_q <= buf_num_replc;
                    rsp_hit_q <= 1'b0;
                    rsp_id_q  <= id_q;
                    rsp_vld_q <= 1'b1;
                    state_q   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_vld       = rsp_vld_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_buf       = rsp_buf_q;
    assign rsp_hit       = rsp_hit_q;
    assign new_buf_req   = new_buf_req_q;
    assign ref_buf_numbr = ref_buf_q;

endmodule
`default_nettype wire

// File: tb/tb_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_buf_sched
// Desc     : Directed self-checking bench for buf_sched. Honours
//            BUF_SCHED_PREFILL_EN to select the matching directed sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buf_sched;

    localparam int c_TAG_W = 8;
    localparam int c_HIT   = 0;
    localparam int c_PRE   = 1;
    localparam int c_LFU   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req0_vld, req1_vld;
    logic [c_TAG_W-1:0] req0_tag, req1_tag;
    logic               req0_rdy, req1_rdy;
    logic               rsp_vld, rsp_id, rsp_hit, rsp_rdy;
    logic [1:0]         rsp_buf, ref_buf_numbr, buf_num_replc;
    logic               new_buf_req;

    int n_chk = 0;
    int n_err = 0;

    buf_sched #(.TAG_W(c_TAG_W)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_vld      (req0_vld),
        .req0_tag      (req0_tag),
        .req0_rdy      (req0_rdy),
        .req1_vld      (req1_vld),
        .req1_tag      (req1_tag),
        .req1_rdy      (req1_rdy),
        .rsp_vld       (rsp_vld),
        .rsp_id        (rsp_id),
        .rsp_buf       (rsp_buf),
        .rsp_hit       (rsp_hit),
        .rsp_rdy       (rsp_rdy),
        .new_buf_req   (new_buf_req),
        .ref_buf_numbr (ref_buf_numbr),
        .buf_num_replc (buf_num_replc)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from drive to response handshake.
    // mode: c_HIT / c_PRE (direct fill) / c_LFU (victim from buf_num_replc)
    task automatic xact(input string nm, input logic id, input logic [7:0] tag,
                        input int mode, input logic [1:0] victim,
                        input logic [1:0] exp_buf, input int stall);
        logic exp_hit;
        exp_hit = (mode == c_HIT);
        if (id) begin req1_vld = 1'b1; req1_tag = tag; end
        else    begin req0_vld = 1'b1; req0_tag = tag; end
        #1;
        chk_eq({nm, ":grant"}, {30'd0, req1_rdy, req0_rdy}, id ? 32'd2 : 32'd1);
        tick();                                   // accept edge N
        if (id) req1_vld = 1'b0; else req0_vld = 1'b0;
        chk_eq({nm, ":lookup"}, {28'd0, rsp_vld, new_buf_req, req1_rdy, req0_rdy}, 32'd0);
        buf_num_replc = victim ^ 2'b11;
        tick();                                   // after N+1
        if (mode == c_LFU) begin
            chk_eq({nm, ":newreq"}, {30'd0, new_buf_req, rsp_vld}, 32'd2);
            tick();                               // after N+2, in WAIT
            chk_eq({nm, ":pulse"}, {30'd0, new_buf_req, rsp_vld}, 32'd0);
            buf_num_replc = victim;
            tick();                               // after N+3
        end
        chk_eq({nm, ":rsp"}, {27'd0, rsp_vld, new_buf_req, rsp_hit, rsp_buf},
               {27'd0, 1'b1, 1'b0, exp_hit, exp_buf});
        chk_eq({nm, ":id_ref"}, {29'd0, rsp_id, ref_buf_numbr}, {29'd0, id, exp_buf});
        for (int s = 0; s < stall; s++) begin
            tick();
            chk_eq({nm, ":stall"}, {26'd0, rsp_vld, rsp_id, rsp_buf, rsp_hit, req0_rdy | req1_rdy},
                   {26'd0, 1'b1, id, exp_buf, exp_hit, 1'b0});
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk_eq({nm, ":done"}, {31'd0, rsp_vld}, 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk_eq(nm, {23'd0, rsp_vld, rsp_id, rsp_buf, rsp_hit, new_buf_req, ref_buf_numbr,
                    req0_rdy, req1_rdy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_vld = 1'b1; req0_tag = 8'h10;
        req1_vld = 1'b0; req1_tag = 8'h00;
        rsp_rdy = 1'b0;
        buf_num_replc = 2'd0;
        tick();
        tick();
        chk_all_zero("reset_state");
        req0_vld = 1'b0;
        rst_n = 1'b1;

`ifdef BUF_SCHED_PREFILL_EN
        xact("pre_t1", 1'b0, 8'h01, c_PRE, 2'd0, 2'd0, 0);
        xact("pre_t2", 1'b1, 8'h02, c_PRE, 2'd0, 2'd1, 0);
        xact("pre_t3", 1'b0, 8'h03, c_PRE, 2'd0, 2'd2, 0);
        xact("pre_t4", 1'b1, 8'h04, c_PRE, 2'd0, 2'd3, 0);
        xact("pre_t5", 1'b0, 8'h05, c_LFU, 2'd1, 2'd1, 0);
        xact("pre_t2b", 1'b1, 8'h02, c_LFU, 2'd3, 2'd3, 0);
        xact("pre_t1h", 1'b0, 8'h01, c_HIT, 2'd0, 2'd0, 0);
        xact("pre_t5h", 1'b1, 8'h05, c_HIT, 2'd0, 2'd1, 0);
`else
        // First miss after reset, victim 2
        xact("miss10", 1'b0, 8'h10, c_LFU, 2'd2, 2'd2, 0);
        xact("hit10", 1'b0, 8'h10, c_HIT, 2'd0, 2'd2, 0);
        xact("miss22", 1'b1, 8'h22, c_LFU, 2'd1, 2'd1, 0);

        // Simultaneous pair with pointer 0, response stalled 5 cycles
        req1_vld = 1'b1; req1_tag = 8'h22;
        xact("arb1_r0", 1'b0, 8'h10, c_HIT, 2'd0, 2'd2, 5);
        xact("arb1_r1", 1'b1, 8'h22, c_HIT, 2'd0, 2'd1, 0);
        // Second pair: req1 was left waiting last time, so it goes first
        req0_vld = 1'b1; req0_tag = 8'h10;
        xact("arb2_r1", 1'b1, 8'h22, c_HIT, 2'd0, 2'd1, 0);
        xact("arb2_r0", 1'b0, 8'h10, c_HIT, 2'd0, 2'd2, 0);

        // Third pair (req0 wins, pointer -> 1), then reset while in WAIT
        req1_vld = 1'b1; req1_tag = 8'h44;
        req0_vld = 1'b1; req0_tag = 8'h33;
        #1;
        chk_eq("arb3:grant", {30'd0, req1_rdy, req0_rdy}, 32'd1);
        tick();
        req0_vld = 1'b0;
        tick();
        chk_eq("abort:newreq", {31'd0, new_buf_req}, 32'd1);
        tick();
        chk_eq("abort:wait", {30'd0, new_buf_req, rsp_vld}, 32'd0);
        buf_num_replc = 2'd1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort:async_zero");
        tick();
        chk_all_zero("abort:held_zero");
        rst_n = 1'b1;
        // Pointer back at 0 and the aborted tag must miss
        xact("post_33", 1'b0, 8'h33, c_LFU, 2'd0, 2'd0, 0);
        xact("post_44", 1'b1, 8'h44, c_LFU, 2'd3, 2'd3, 0);
        xact("post_10", 1'b0, 8'h10, c_LFU, 2'd1, 2'd1, 0);
        // Replacement evicts the old occupant
        xact("evict55", 1'b1, 8'h55, c_LFU, 2'd0, 2'd0, 0);
        xact("re_33", 1'b0, 8'h33, c_LFU, 2'd2, 2'd2, 0);
        xact("hit55", 1'b1, 8'h55, c_HIT, 2'd0, 2'd0, 0);
        xact("hit44", 1'b0, 8'h44, c_HIT, 2'd0, 2'd3, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
